// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: control inputs (start, abort, pattern, repeat_cnt, gap_len) and serial outputs (x_out, x_valid, busy, frame_done) of the pattern transmitter
interface seq_pattern_tx_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap_len;
    logic             x_out;
    logic             x_valid;
    logic             busy;
    logic             frame_done;
    modport master (
        output start, abort, pattern, repeat_cnt, gap_len,
        input  x_out, x_valid, busy, frame_done
    );
    modport slave (
        input  start, abort, pattern, repeat_cnt, gap_len,
        output x_out, x_valid, busy, frame_done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: MSB-first serial pattern transmitter with repeats and gaps; ports clk, reset (async high), bus (slave: start/abort/pattern/repeat_cnt/gap_len in, x_out/x_valid/busy/frame_done out)
module seq_pattern_tx #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
) (
    input logic           clk,
    input logic           reset,
    seq_pattern_tx_if.slave bus
);
    localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BW-1:0] LAST = BW'(PAT_W - 1);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
    state_t           state, state_n;
    logic [PAT_W-1:0] pat_reg, pat_n, sh;
    logic [BW-1:0]    bit_idx, bit_n;
    logic [CNT_W-1:0] reps_left, reps_n;
    logic [GAP_W-1:0] gap_reg, gap_reg_n, gap_cnt, gap_cnt_n;
    logic             x_out_n, x_valid_n, busy_n, done_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            pat_reg        <= '0;
            bit_idx        <= '0;
            reps_left      <= '0;
            gap_reg        <= '0;
            gap_cnt        <= '0;
            bus.x_out      <= 1'b0;
            bus.x_valid    <= 1'b0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            state          <= state_n;
            pat_reg        <= pat_n;
            bit_idx        <= bit_n;
            reps_left      <= reps_n;
            gap_reg        <= gap_reg_n;
            gap_cnt        <= gap_cnt_n;
            bus.x_out      <= x_out_n;
            bus.x_valid    <= x_valid_n;
            bus.busy       <= busy_n;
            bus.frame_done <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        pat_n     = pat_reg;
        bit_n     = bit_idx;
        reps_n    = reps_left;
        gap_reg_n = gap_reg;
        gap_cnt_n = gap_cnt;
        case (state)
            IDLE:
                if (bus.start && !bus.abort && |bus.repeat_cnt) begin
                    state_n   = SHIFT;
                    pat_n     = bus.pattern;
                    reps_n    = bus.repeat_cnt;
                    gap_reg_n = bus.gap_len;
                    bit_n     = '0;
                end
            SHIFT:
                if (bus.abort) state_n = IDLE;
                else if (bit_idx != LAST) bit_n = bit_idx + 1'b1;
                else if (reps_left == CNT_W'(1)) state_n = DONE;
                else begin
                    reps_n    = reps_left - 1'b1;
                    bit_n     = '0;
                    gap_cnt_n = gap_reg;
                    state_n   = (gap_reg == '0) ? SHIFT : GAP;
                end
            GAP:
                if (bus.abort) state_n = IDLE;
                else if (gap_cnt == GAP_W'(1)) begin
                    state_n = SHIFT;
                    bit_n   = '0;
                end else gap_cnt_n = gap_cnt - 1'b1;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they land in flops one cycle ahead.
    always_comb begin
        sh        = pat_n << bit_n;
        x_valid_n = (state_n == SHIFT);
        x_out_n   = x_valid_n & sh[PAT_W-1];
        busy_n    = (state_n != IDLE);
        done_n    = (state_n == DONE);
    end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed self-checking bench for seq_pattern_tx
module tb_seq_pattern_tx;
    logic clk;
    logic reset;
    int errors;
    int checks;
    logic [31:0] cv, cx, cb, cf;

    seq_pattern_tx_if #(.PAT_W(4), .CNT_W(4), .GAP_W(4)) bus ();

    seq_pattern_tx #(.PAT_W(4), .CNT_W(4), .GAP_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [3:0] p, input logic [3:0] rc, input logic [3:0] gl);
        bus.pattern    = p;
        bus.repeat_cnt = rc;
        bus.gap_len    = gl;
        bus.start      = 1'b1;
    endtask

    // Records n cycles, earliest cycle in the highest captured bit; optional
    // one-edge abort after cycle abort_at, optional start/input noise.
    task automatic capture(input int n, input int abort_at, input bit noise);
        cv = '0; cx = '0; cb = '0; cf = '0;
        for (int c = 1; c <= n; c++) begin
            tick();
            cv = {cv[30:0], bus.x_valid};
            cx = {cx[30:0], bus.x_out};
            cb = {cb[30:0], bus.busy};
            cf = {cf[30:0], bus.frame_done};
            bus.abort = (c == abort_at);
            bus.start = noise;
            if (noise) begin
                bus.pattern    = 4'($urandom);
                bus.repeat_cnt = 4'($urandom_range(1, 15));
                bus.gap_len    = 4'($urandom);
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.pattern = '0; bus.repeat_cnt = '0; bus.gap_len = '0;
        #1 reset = 1'b1;
        tick(); tick();
        #2 reset = 1'b0;
        tick();
        if (bus.x_out !== 1'b0) begin errors++; $display("FAIL reset x_out got=%b exp=0", bus.x_out); end
        checks++;
        if (bus.x_valid !== 1'b0) begin errors++; $display("FAIL reset x_valid got=%b exp=0", bus.x_valid); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy got=%b exp=0", bus.busy); end
        checks++;
        if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done got=%b exp=0", bus.frame_done); end
        checks++;
    endtask

    task automatic test_single();
        launch(4'b1101, 4'd1, 4'd0);
        capture(6, 0, 1'b0);
        if (cx[5:0] !== 6'b110100) begin errors++; $display("FAIL single x_out got=%b exp=110100", cx[5:0]); end
        checks++;
        if (cv[5:0] !== 6'b111100) begin errors++; $display("FAIL single x_valid got=%b exp=111100", cv[5:0]); end
        checks++;
        if (cb[5:0] !== 6'b111110) begin errors++; $display("FAIL single busy got=%b exp=111110", cb[5:0]); end
        checks++;
        if (cf[5:0] !== 6'b000010) begin errors++; $display("FAIL single frame_done got=%b exp=000010", cf[5:0]); end
        checks++;
    endtask

    task automatic test_gap();
        launch(4'b1011, 4'd2, 4'd2);
        capture(12, 0, 1'b0);
        if (cx[11:0] !== 12'b101100101100) begin errors++; $display("FAIL gap x_out got=%b exp=101100101100", cx[11:0]); end
        checks++;
        if (cv[11:0] !== 12'b111100111100) begin errors++; $display("FAIL gap x_valid got=%b exp=111100111100", cv[11:0]); end
        checks++;
        if (cb[11:0] !== 12'b111111111110) begin errors++; $display("FAIL gap busy got=%b exp=111111111110", cb[11:0]); end
        checks++;
        if (cf[11:0] !== 12'b000000000010) begin errors++; $display("FAIL gap frame_done got=%b exp=000000000010", cf[11:0]); end
        checks++;
    endtask

    task automatic test_back_to_back();
        launch(4'b1001, 4'd3, 4'd0);
        capture(14, 0, 1'b0);
        if (cx[13:0] !== 14'b10011001100100) begin errors++; $display("FAIL b2b x_out got=%b exp=10011001100100", cx[13:0]); end
        checks++;
        if (cv[13:0] !== 14'b11111111111100) begin errors++; $display("FAIL b2b x_valid got=%b exp=11111111111100", cv[13:0]); end
        checks++;
        if (cb[13:0] !== 14'b11111111111110) begin errors++; $display("FAIL b2b busy got=%b exp=11111111111110", cb[13:0]); end
        checks++;
        if (cf[13:0] !== 14'b00000000000010) begin errors++; $display("FAIL b2b frame_done got=%b exp=00000000000010", cf[13:0]); end
        checks++;
    endtask

    task automatic test_max_counts();
        int nv, nx, nb, nf, ng;
        nv = 0; nx = 0; nb = 0; nf = 0; ng = 0;
        launch(4'b1010, 4'd15, 4'd15);
        for (int c = 0; c < 300; c++) begin
            tick();
            bus.start = 1'b0;
            nv += int'(bus.x_valid);
            nx += int'(bus.x_out);
            nb += int'(bus.busy);
            nf += int'(bus.frame_done);
            ng += int'(bus.busy & ~bus.x_valid & ~bus.frame_done);
        end
        if (nv !== 60) begin errors++; $display("FAIL max valid_bits got=%0d exp=60", nv); end
        checks++;
        if (nx !== 30) begin errors++; $display("FAIL max one_bits got=%0d exp=30", nx); end
        checks++;
        if (nb !== 271) begin errors++; $display("FAIL max busy_cycles got=%0d exp=271", nb); end
        checks++;
        if (ng !== 210) begin errors++; $display("FAIL max gap_cycles got=%0d exp=210", ng); end
        checks++;
        if (nf !== 1) begin errors++; $display("FAIL max frame_done_count got=%0d exp=1", nf); end
        checks++;
    endtask

    task automatic test_ignored_inputs();
        launch(4'b1101, 4'd1, 4'd0);
        capture(6, 0, 1'b1);
        if (cx[5:0] !== 6'b110100) begin errors++; $display("FAIL ignore x_out got=%b exp=110100", cx[5:0]); end
        checks++;
        if (cv[5:0] !== 6'b111100) begin errors++; $display("FAIL ignore x_valid got=%b exp=111100", cv[5:0]); end
        checks++;
        if (cb[5:0] !== 6'b111110) begin errors++; $display("FAIL ignore busy got=%b exp=111110", cb[5:0]); end
        checks++;
        if (cf[5:0] !== 6'b000010) begin errors++; $display("FAIL ignore frame_done got=%b exp=000010", cf[5:0]); end
        checks++;
        tick();
        launch(4'b1111, 4'd0, 4'd0);
        capture(3, 0, 1'b0);
        if (cb[2:0] !== 3'b000) begin errors++; $display("FAIL zero_rep busy got=%b exp=000", cb[2:0]); end
        checks++;
        if (cv[2:0] !== 3'b000) begin errors++; $display("FAIL zero_rep x_valid got=%b exp=000", cv[2:0]); end
        checks++;
        if (cf[2:0] !== 3'b000) begin errors++; $display("FAIL zero_rep frame_done got=%b exp=000", cf[2:0]); end
        checks++;
    endtask

    task automatic test_abort();
        launch(4'b1011, 4'd2, 4'd2);
        capture(9, 8, 1'b0);
        if (cx[8:0] !== 9'b101100100) begin errors++; $display("FAIL abort_shift x_out got=%b exp=101100100", cx[8:0]); end
        checks++;
        if (cv[8:0] !== 9'b111100110) begin errors++; $display("FAIL abort_shift x_valid got=%b exp=111100110", cv[8:0]); end
        checks++;
        if (cb[8:0] !== 9'b111111110) begin errors++; $display("FAIL abort_shift busy got=%b exp=111111110", cb[8:0]); end
        checks++;
        if (cf[8:0] !== 9'b000000000) begin errors++; $display("FAIL abort_shift frame_done got=%b exp=000000000", cf[8:0]); end
        checks++;
        launch(4'b1101, 4'd1, 4'd0);
        capture(6, 0, 1'b0);
        if (cx[5:0] !== 6'b110100) begin errors++; $display("FAIL restart x_out got=%b exp=110100", cx[5:0]); end
        checks++;
        if (cf[5:0] !== 6'b000010) begin errors++; $display("FAIL restart frame_done got=%b exp=000010", cf[5:0]); end
        checks++;
        launch(4'b1011, 4'd2, 4'd2);
        capture(6, 5, 1'b0);
        if (cv[5:0] !== 6'b111100) begin errors++; $display("FAIL abort_gap x_valid got=%b exp=111100", cv[5:0]); end
        checks++;
        if (cb[5:0] !== 6'b111110) begin errors++; $display("FAIL abort_gap busy got=%b exp=111110", cb[5:0]); end
        checks++;
        if (cf[5:0] !== 6'b000000) begin errors++; $display("FAIL abort_gap frame_done got=%b exp=000000", cf[5:0]); end
        checks++;
        launch(4'b0110, 4'd1, 4'd0);
        capture(6, 0, 1'b0);
        if (cx[5:0] !== 6'b011000) begin errors++; $display("FAIL restart_gap x_out got=%b exp=011000", cx[5:0]); end
        checks++;
        launch(4'b1101, 4'd1, 4'd0);
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_priority busy got=%b exp=0", bus.busy); end
        checks++;
        launch(4'b1101, 4'd1, 4'd0);
        capture(6, 5, 1'b0);
        if (cf[5:0] !== 6'b000010) begin errors++; $display("FAIL abort_done frame_done got=%b exp=000010", cf[5:0]); end
        checks++;
        if (cb[5:0] !== 6'b111110) begin errors++; $display("FAIL abort_done busy got=%b exp=111110", cb[5:0]); end
        checks++;
    endtask

    task automatic test_reset_mid_run();
        launch(4'b1101, 4'd1, 4'd0);
        capture(2, 0, 1'b0);
        #2 reset = 1'b1;
        #1;
        if ({bus.x_out, bus.x_valid, bus.busy, bus.frame_done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid outputs got=%b exp=0000", {bus.x_out, bus.x_valid, bus.busy, bus.frame_done});
        end
        checks++;
        tick();
        #2 reset = 1'b0;
        capture(4, 0, 1'b0);
        if ({cb[3:0], cf[3:0]} !== 8'h00) begin errors++; $display("FAIL reset_mid idle busy/frame_done got=%b exp=00000000", {cb[3:0], cf[3:0]}); end
        checks++;
        launch(4'b1101, 4'd1, 4'd0);
        capture(6, 0, 1'b0);
        if (cx[5:0] !== 6'b110100) begin errors++; $display("FAIL reset_rerun x_out got=%b exp=110100", cx[5:0]); end
        checks++;
        if (cv[5:0] !== 6'b111100) begin errors++; $display("FAIL reset_rerun x_valid got=%b exp=111100", cv[5:0]); end
        checks++;
        if (cb[5:0] !== 6'b111110) begin errors++; $display("FAIL reset_rerun busy got=%b exp=111110", cb[5:0]); end
        checks++;
        if (cf[5:0] !== 6'b000010) begin errors++; $display("FAIL reset_rerun frame_done got=%b exp=000010", cf[5:0]); end
        checks++;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_gap();
        test_back_to_back();
        test_max_counts();
        test_ignored_inputs();
        test_abort();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter: shifts a programmable PAT_W-bit pattern out MSB-first on a single-bit line, with a per-bit valid strobe.
- Optional repetition count and inter-frame gap.
- Serves as the stimulus/transmit end for the serial bit-sequence detectors in the same design.
- Also used as an on-chip pattern source for loopback self-test of those detectors.

Parameters:
- PAT_W, 4, pattern length in bits (≥2).
- CNT_W, 4, width of repeat count.
- GAP_W, 4, width of gap length (idle cycles between repeats).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to begin transmission; sampled only in IDLE.
- abort  input  1  synchronous cancel of the current transmission.
- pattern  input  PAT_W  bits to send; bit PAT_W-1 is sent first.
- repeat_cnt  input  CNT_W  number of pattern repetitions; 0 means start is ignored.
- gap_len  input  GAP_W  idle cycles inserted between repetitions.
- x_out  output  1  serial data, registered.
- x_valid  output  1  high while x_out carries a pattern bit, registered.
- busy  output  1  high from the first bit until frame_done, inclusive.
- frame_done  output  1  one-cycle pulse after the last bit of the last repetition.

Behaviour:
- Reset: clk is the clock; reset is asynchronous, active-high.
  - State=IDLE; x_out=0, x_valid=0, busy=0, frame_done=0.
  - Internal pattern, repeat and gap registers cleared.
- All outputs are registered and change only on rising clk.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - Outputs 0.
  - On a clock edge with start=1, abort=0 and repeat_cnt≠0: latch pattern, repeat_cnt and gap_len; bit_idx=0; go to SHIFT.
  - The first bit (pattern[PAT_W-1]) appears on x_out with x_valid=1 and busy=1 in the cycle immediately after that edge. Latency is 1 cycle.
  - start with repeat_cnt=0: ignored, stays IDLE, no frame_done.
- SHIFT:
  - x_out = pat_reg[PAT_W-1-bit_idx], x_valid=1, for exactly PAT_W consecutive cycles per repetition.
  - After the last bit (bit_idx=PAT_W-1):
    - reps_left==1 → DONE.
    - else gap_len==0 → SHIFT again from bit 0, reps_left-1, no bubble.
    - else → GAP, reps_left-1.
- GAP:
  - x_out=0, x_valid=0, busy=1 for exactly gap_len cycles, then SHIFT from bit 0.
- DONE:
  - One cycle: frame_done=1, busy=1, x_valid=0, x_out=0.
  - Then IDLE.
  - A new start is accepted at the earliest on the edge ending the first IDLE cycle.
- start while not in IDLE (SHIFT/GAP/DONE): ignored.
- Input stability: pattern, repeat_cnt and gap_len are used only via the copies latched at start. Changes during busy have no effect.
- abort:
  - Sampled at any edge in SHIFT or GAP: next cycle is IDLE with all outputs 0. No frame_done.
  - abort in DONE has no effect; frame_done still pulses.
  - abort has priority over start in IDLE (start not accepted).
- Asynchronous reset mid-transmission: immediate return to IDLE outputs. No frame_done. Internal counters cleared.
- Counters:
  - bit_idx is ceil(log2(PAT_W)) bits; wraps to 0 on each new repetition.
  - reps_left is CNT_W bits, loaded with repeat_cnt.
  - gap counter is GAP_W bits, loaded with gap_len.
  - Maximum repetitions (2^CNT_W−1) and maximum gap (2^GAP_W−1) must be handled with no overflow.
- Total busy cycles for a completed run = R·PAT_W + (R−1)·G + 1, where R = repeat_cnt and G = gap_len.

Test Plan:
1. Single repetition: pattern=4'b1101, repeat_cnt=1, gap_len=0, start pulse at edge E0.
   → cycles after E0: x_out=1,1,0,1 with x_valid=1; cycle 5: frame_done=1, x_valid=0; cycle 6: busy=0.
2. Repeat with gap: pattern=4'b1011, repeat_cnt=2, gap_len=2.
   → x_valid sequence 1111 00 1111 0.
   → x_out sequence 1011 00 1011.
   → frame_done only in cycle 11; busy=1 for 11 cycles.
3. Back-to-back and max counts:
   - pattern=4'b1001, repeat_cnt=3, gap_len=0 → 12 consecutive valid bits 100110011001, then frame_done.
   - repeat_cnt=15, gap_len=15 → 60 valid bits, 14 gaps of 15 cycles, one frame_done.
4. Ignored inputs:
   - start asserted repeatedly during busy, and pattern changed mid-run → output stream identical to case 1, a single frame_done.
   - start with repeat_cnt=0 → busy stays 0, no output.
5. Abort: case 2 setup with abort=1 at the 2nd bit of the 2nd repetition, and separately in GAP.
   → next cycle x_valid=0, busy=0, no frame_done.
   → a new start one cycle later transmits correctly.
6. Reset mid-run: assert reset asynchronously (between edges) during SHIFT.
   → outputs go to 0 immediately, no frame_done.
   → after release, case 1 reproduces exactly.
